uart_tx_scheduler: RTL and testbench

- Controller for the shared UART transmit FIFO.
- Arbitrates NUM_REQ byte producers onto the FIFO enqueue port using round-robin.
- Sequences FIFO dequeues into the UART transmitter through a start/busy handshake.
- Sits between the producer blocks, the FIFO instance (MAX_ELEMENTS deep, DATA_BITS wide) and the UART TX serializer.

---
 rtl/uart_tx_scheduler.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding the shared UART TX FIFO, plus a drain FSM that pops the FIFO
// and hands each byte to the serializer through a start/busy handshake.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [DATA_BITS-1:0]         fifo_enqueue,
    output logic                         fifo_req_enqueue,
    input  logic                         fifo_isFull,
    input  logic                         fifo_isEmpty,
    output logic                         fifo_req_dequeue,
    input  logic [DATA_BITS-1:0]         fifo_dequeue,
    input  logic                         fifo_dequeue_valid,
    input  logic                         drain_en,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [CNT_BITS-1:0]          bytes_sent,
    output logic [2:0]                   drain_state
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPop      = 3'd1,
        StLoad     = 3'd2,
        StWaitBusy = 3'd3,
        StWaitIdle = 3'd4
    } drain_st_e;

    drain_st_e             state_q, state_d;
    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  fifo_req_dequeue_q, fifo_req_dequeue_d;
    logic                  tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
    logic [CNT_BITS-1:0]   bytes_sent_q, bytes_sent_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic                  retried_q, retried_d;

    logic                  grant_vld;
    logic [PtrW-1:0]       grant_idx;
    int unsigned           cand;
    logic [PtrW-1:0]       cand_idx;

    // Search upward from rr_ptr, wrapping at NUM_REQ; first requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = k + 32'(rr_ptr_q);
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PtrW'(cand);
            if (!grant_vld && !fifo_isFull && req[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
        fifo_enqueue     = grant_vld ? req_data[grant_idx*DATA_BITS +: DATA_BITS] : '0;
        fifo_req_enqueue = grant_vld;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= StIdle;
            rr_ptr_q           <= '0;
            fifo_req_dequeue_q <= 1'b0;
            tx_start_q         <= 1'b0;
            tx_data_q          <= '0;
            bytes_sent_q       <= '0;
            wait_cnt_q         <= '0;
            retried_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            rr_ptr_q           <= rr_ptr_d;
            fifo_req_dequeue_q <= fifo_req_dequeue_d;
            tx_start_q         <= tx_start_d;
            tx_data_q          <= tx_data_d;
            bytes_sent_q       <= bytes_sent_d;
            wait_cnt_q         <= wait_cnt_d;
            retried_q          <= retried_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (drain_en && !fifo_isEmpty) state_d = StPop;
            StPop:      if (fifo_dequeue_valid) state_d = StLoad;
            StLoad:     state_d = StWaitBusy;
            StWaitBusy: if (tx_busy) state_d = StWaitIdle;
            StWaitIdle: if (!tx_busy) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_req_dequeue_d = 1'b0;
        tx_start_d         = 1'b0;
        tx_data_d          = tx_data_q;
        bytes_sent_d       = bytes_sent_q;
        wait_cnt_d         = '0;
        retried_d          = retried_q;
        case (state_q)
            StIdle: begin
                fifo_req_dequeue_d = drain_en && !fifo_isEmpty;
            end
            StLoad: begin
                tx_data_d  = fifo_dequeue;
                tx_start_d = 1'b1;
                retried_d  = 1'b0;
            end
            StWaitBusy: begin
                // After four silent cycles the start pulse is repeated exactly once.
                if (!tx_busy) begin
                    if (wait_cnt_q == 2'd3) begin
                        wait_cnt_d = wait_cnt_q;
                        if (!retried_q) begin
                            tx_start_d = 1'b1;
                            retried_d  = 1'b1;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + 2'd1;
                    end
                end
            end
            StWaitIdle: begin
                if (!tx_busy && (bytes_sent_q != '1)) begin
                    bytes_sent_d = bytes_sent_q + CNT_BITS'(1);
                end
            end
            default: ;
        endcase
    end

    assign fifo_req_dequeue = fifo_req_dequeue_q;
    assign tx_start         = tx_start_q;
    assign tx_data          = tx_data_q;
    assign bytes_sent       = bytes_sent_q;
    assign drain_state      = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: 4-deep FIFO and serializer models, directed stimulus, and a
// scoreboard of expected transmitted bytes checked by an independent monitor.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  grant;
    logic [7:0]  fifo_enqueue;
    logic        fifo_req_enqueue;
    logic        fifo_isFull = 1'b0;
    logic        fifo_isEmpty = 1'b1;
    logic        fifo_req_dequeue;
    logic [7:0]  fifo_dequeue = '0;
    logic        fifo_dequeue_valid = 1'b0;
    logic        drain_en = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [15:0] bytes_sent;
    logic [2:0]  drain_state;

    int checks = 0;
    int errors = 0;
    int n_starts = 0;
    int n_pops = 0;
    int enq_count = 0;
    int overflow = 0;
    int busy_mode = 0;  // 0: serializer model, 1: tied high, 2: tied low
    int ser_cnt = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_tx_scheduler #(
        .NUM_REQ  (4),
        .DATA_BITS(8),
        .CNT_BITS (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_data          (req_data),
        .grant             (grant),
        .fifo_enqueue      (fifo_enqueue),
        .fifo_req_enqueue  (fifo_req_enqueue),
        .fifo_isFull       (fifo_isFull),
        .fifo_isEmpty      (fifo_isEmpty),
        .fifo_req_dequeue  (fifo_req_dequeue),
        .fifo_dequeue      (fifo_dequeue),
        .fifo_dequeue_valid(fifo_dequeue_valid),
        .drain_en          (drain_en),
        .tx_data           (tx_data),
        .tx_start          (tx_start),
        .tx_busy           (tx_busy),
        .bytes_sent        (bytes_sent),
        .drain_state       (drain_state)
    );

    always #5 clk = ~clk;

    // FIFO model: flags update on the edge after the operation, read data one cycle after a pop.
    always @(posedge clk) begin
        fifo_dequeue_valid <= 1'b0;
        if (fifo_req_dequeue && fq.size() > 0) begin
            fifo_dequeue       <= fq[0];
            fifo_dequeue_valid <= 1'b1;
            void'(fq.pop_front());
        end
        if (fifo_req_enqueue) begin
            enq_count++;
            if (fq.size() < 4) fq.push_back(fifo_enqueue);
            else overflow++;
        end
        fifo_isEmpty <= (fq.size() == 0);
        fifo_isFull  <= (fq.size() == 4);
    end

    // Serializer model: busy for 10 cycles after each start.
    always @(posedge clk) begin
        if (busy_mode == 1) begin
            tx_busy <= 1'b1;
            ser_cnt <= 0;
        end else if (busy_mode == 2) begin
            tx_busy <= 1'b0;
            ser_cnt <= 0;
        end else if (ser_cnt == 0) begin
            if (tx_start) begin
                tx_busy <= 1'b1;
                ser_cnt <= 10;
            end else begin
                tx_busy <= 1'b0;
            end
        end else begin
            ser_cnt <= ser_cnt - 1;
            if (ser_cnt == 1) tx_busy <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req_v);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_req_dequeue) begin
                n_pops++;
                check("pop_while_empty", {31'd0, fifo_isEmpty}, 32'd0);
            end
            if (tx_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_start_unexpected: got tx_data 0x%0h, required no tx_start",
                             tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("scoreboard_tx_data", {24'd0, tx_data}, {24'd0, exp_b});
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_bytes(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (bytes_sent != 16'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {16'd0, bytes_sent}, target);
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (drain_state != 3'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {29'd0, drain_state}, target);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int p0;
        int s0;
        int e0;

        // Reset state, then empty FIFO with draining enabled.
        do_reset();
        check("rst_grant", {28'd0, grant}, 0);
        check("rst_req_enq", {31'd0, fifo_req_enqueue}, 0);
        check("rst_req_deq", {31'd0, fifo_req_dequeue}, 0);
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_bytes_sent", {16'd0, bytes_sent}, 0);
        check("rst_state", {29'd0, drain_state}, 0);
        drain_en = 1'b1;
        p0 = n_pops;
        s0 = n_starts;
        repeat (20) @(negedge clk);
        check("empty_no_pop", n_pops - p0, 0);
        check("empty_no_start", n_starts - s0, 0);

        // All producers requesting, no draining: four rotating grants, then full.
        do_reset();
        drain_en  = 1'b0;
        busy_mode = 1;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hA0 + 8'(i);
        e0  = enq_count;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_grant", {28'd0, grant}, 4'b0001 << i);
            check("rr_enq_data", {24'd0, fifo_enqueue}, 32'hA0 + i);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            check("full_grant", {28'd0, grant}, 0);
            check("full_req_enq", {31'd0, fifo_req_enqueue}, 0);
            @(negedge clk);
        end
        req = 4'b0000;
        check("full_enq_count", enq_count - e0, 4);
        check("full_overflow", overflow, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
        busy_mode = 0;
        drain_en  = 1'b1;
        wait_bytes(4, 200, "full_drain_bytes_sent");

        // Single byte from producer 2: pop and start timing.
        do_reset();
        req_data[2*8 +: 8] = 8'hA5;
        exp_q.push_back(8'hA5);
        req = 4'b0100;
        #1;
        check("a5_grant", {28'd0, grant}, 4'b0100);
        check("a5_enq_data", {24'd0, fifo_enqueue}, 32'hA5);
        check("a5_req_enq", {31'd0, fifo_req_enqueue}, 1);
        @(negedge clk);
        req = 4'b0000;
        check("a5_no_early_pop", {31'd0, fifo_req_dequeue}, 0);
        @(negedge clk);
        check("a5_pop_rise", {31'd0, fifo_req_dequeue}, 1);
        check("a5_state_pop", {29'd0, drain_state}, 1);
        @(negedge clk);
        check("a5_pop_single", {31'd0, fifo_req_dequeue}, 0);
        @(negedge clk);
        check("a5_state_load", {29'd0, drain_state}, 2);
        check("a5_start_not_yet", {31'd0, tx_start}, 0);
        @(negedge clk);
        check("a5_start", {31'd0, tx_start}, 1);
        check("a5_tx_data", {24'd0, tx_data}, 32'hA5);
        check("a5_state_wait_busy", {29'd0, drain_state}, 3);
        @(negedge clk);
        check("a5_start_single", {31'd0, tx_start}, 0);
        wait_bytes(1, 40, "a5_bytes_sent");

        // Ordering through one producer.
        do_reset();
        s0 = n_starts;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        req = 4'b0001;
        req_data[7:0] = 8'h11;
        @(negedge clk);
        req_data[7:0] = 8'h22;
        @(negedge clk);
        req_data[7:0] = 8'h33;
        @(negedge clk);
        req = 4'b0000;
        wait_bytes(3, 150, "order_bytes_sent");
        check("order_start_count", n_starts - s0, 3);
        check("order_scoreboard_empty", exp_q.size(), 0);

        // Fairness and pointer wrap from producer 3 back to 0.
        do_reset();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'hC0 + 8'(i);
        req = 4'b1000;
        #1;
        check("fair_grant3", {28'd0, grant}, 4'b1000);
        @(negedge clk);
        req = 4'b1001;
        #1;
        check("fair_wrap_grant0", {28'd0, grant}, 4'b0001);
        @(negedge clk);
        req = 4'b0101;
        #1;
        check("fair_alt_grant2", {28'd0, grant}, 4'b0100);
        @(negedge clk);
        #1;
        check("fair_alt_grant0", {28'd0, grant}, 4'b0001);
        @(negedge clk);
        #1;
        check("fair_full_grant", {28'd0, grant}, 0);
        req = 4'b0000;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC0);
        drain_en = 1'b1;
        wait_bytes(4, 200, "fair_bytes_sent");

        // Reset in WAIT_IDLE drops the byte in flight; drain_en gates the next pop.
        busy_mode = 1;
        exp_q.push_back(8'h5A);
        req = 4'b0010;
        req_data[1*8 +: 8] = 8'h5A;
        @(negedge clk);
        req_data[1*8 +: 8] = 8'h6B;
        @(negedge clk);
        req = 4'b0000;
        wait_state(4, 40, "abort_reach_wait_idle");
        drain_en = 1'b0;
        do_reset();
        check("abort_state", {29'd0, drain_state}, 0);
        check("abort_bytes_sent", {16'd0, bytes_sent}, 0);
        check("abort_tx_start", {31'd0, tx_start}, 0);
        check("abort_req_deq", {31'd0, fifo_req_dequeue}, 0);
        busy_mode = 0;
        p0 = n_pops;
        s0 = n_starts;
        repeat (10) @(negedge clk);
        check("abort_gated_pop", n_pops - p0, 0);
        check("abort_gated_start", n_starts - s0, 0);
        exp_q.push_back(8'h6B);
        drain_en = 1'b1;
        wait_bytes(1, 60, "abort_resume_bytes_sent");

        // Serializer never answers: exactly one repeated start, then keep waiting.
        busy_mode = 2;
        s0 = n_starts;
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h77);
        req = 4'b1000;
        req_data[3*8 +: 8] = 8'h77;
        @(negedge clk);
        req = 4'b0000;
        repeat (30) @(negedge clk);
        check("retry_start_count", n_starts - s0, 2);
        check("retry_state_wait_busy", {29'd0, drain_state}, 3);
        busy_mode = 1;
        repeat (3) @(negedge clk);
        check("retry_state_wait_idle", {29'd0, drain_state}, 4);
        busy_mode = 2;
        wait_bytes(2, 20, "retry_bytes_sent");

        check("final_scoreboard_empty", exp_q.size(), 0);
        check("final_overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
